serial_write_queue: RTL and testbench
=====================================

// Module: serial_write_queue
// PURPOSE
//  Queued, parametrised parallel-to-serial writer for the MITM datapath.
//  - Accepts words into an internal FIFO.
//  - Shifts each word out one bit per write_sig pulse. write_sig is the edge-detector output of the external data clock.
//  - Streams queued words back-to-back with no idle bit, so a multi-byte frame can be injected without CPU-timed restarts.
// PARAMETERS
//  BUF_SIZE    8  bits per word
//  DEPTH       4  FIFO depth in words; power of two, >=2
//  LSB_FIRST   0  0: MSB shifted first; 1: LSB shifted first
//  IDLE_LEVEL  1  data_out level while no word is active
// PORTS
//  sys_clk    in   1                     system clock, all logic on rising edge
//  rst        in   1                     synchronous, active-high reset
//  wr_en      in   1                     push data_in into FIFO this cycle
//  data_in    in   BUF_SIZE              word to queue
//  full       out  1                     FIFO holds DEPTH words
//  count      out  $clog2(DEPTH)+1       words queued, excluding the word being shifted
//  overflow   out  1                     1-cycle pulse: wr_en while full, word dropped
//  write_sig  in   1                     1-cycle pulse: advance to next bit
//  data_out   out  1                     current serial bit
//  busy       out  1                     word being shifted, or FIFO non-empty
//  word_done  out  1                     1-cycle pulse when the last bit of a word is consumed
// BEHAVIOUR
//  Reset values
//   - data_out=IDLE_LEVEL; full=0, count=0, overflow=0, busy=0, word_done=0.
//   - FIFO pointers cleared, state IDLE.
//  FSM states: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
//   - IDLE: if FIFO non-empty, pop head into the shift register, bit_cnt=0, go SHIFT.
//     write_sig in IDLE is ignored.
//   - SHIFT: data_out = current bit. On write_sig, advance one bit (MSB- or LSB-first per LSB_FIRST).
//     On the write_sig that consumes bit BUF_SIZE-1, pulse word_done, then:
//       - macro set: go PARITY.
//       - FIFO non-empty: pop and reload in the same cycle, stay SHIFT (back-to-back).
//       - FIFO empty: go IDLE, data_out=IDLE_LEVEL next cycle.
//  Latency
//   - wr_en at cycle N on an empty, idle block: count=1 at N+1; popped at N+1.
//   - First bit on data_out at N+2; busy=1 from N+1.
//  FIFO rules
//   - Push on a full FIFO is dropped and overflow pulses, even if a pop occurs in the same cycle.
//   - Simultaneous push and pop on a non-full FIFO: count unchanged.
//   - Pointers wrap modulo DEPTH.
//  Simultaneous events
//   - rst outranks everything.
//   - write_sig in the same cycle as a reload acts on the outgoing word's last bit only.
//  Reset mid-word: abort the word, flush the FIFO, no word_done. data_out returns to IDLE_LEVEL the next cycle.
//  data_out changes only on sys_clk edges following write_sig or a load, so it is glitch-free.
// CONFIGURATION
//  SERIAL_WRITE_QUEUE_PARITY_EN
//   - Defined: after each word, one extra even-parity bit (XOR of the word) is presented in state PARITY.
//     word_done pulses on the write_sig consuming the parity bit, not the last data bit.
//     Bits per word = BUF_SIZE+1.
//   - Undefined: no parity state, BUF_SIZE bits per word.
// STRUCTURE
//  - Shared package (mitm_pkg): FSM state encodings; helper for the count width.
//  - Sub-module sync_word_fifo (BUF_SIZE, DEPTH):
//    - ports: wr_en, rd_en, data_in, data_out, full, empty, count.
//    - first-word-fall-through output.
//  - Top level: FSM, shift register, bit counter, optional parity register.
// TESTING
//  1. MSB-first, push 0x9C, 8 write_sig pulses -> data_out 1,0,0,1,1,1,0,0; word_done once; busy falls; data_out=1.
//  2. LSB_FIRST=1, push 0xE4 -> 0,0,1,0,0,1,1,1.
//  3. Back-to-back: push 0x9C and 0xE4, 16 pulses -> 16 contiguous bits, no idle bit between words.
//     Two word_done pulses; count 1->0 at the first reload.
//  4. DEPTH=4, push 6 words while idle
//     -> 1 word popped to the shifter, then full=1 after the 5th push.
//     -> overflow pulses on the 6th push; that word is never emitted.
//  5. rst mid-word after 3 pulses of 0xE4
//     -> data_out=IDLE_LEVEL next cycle, count=0, busy=0, no word_done.
//     -> a following push of 0x9C serialises correctly.
//  6. With SERIAL_WRITE_QUEUE_PARITY_EN, push 0x9D -> 1,0,0,1,1,1,0,1 then parity bit 1; word_done after the 9th pulse.

Source files
------------

// File: rtl/mitm_pkg.sv
// Shared definitions for the MITM datapath: serial writer FSM states and
// the width helper for word counters.
package mitm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } wq_state_t;

    // A counter that must reach DEPTH itself needs one bit beyond the pointer width.
    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Synchronous word FIFO with first-word-fall-through output: data_out always
// shows the head word while empty is low. DEPTH must be a power of two.
module sync_word_fifo
    import mitm_pkg::*;
#(
    parameter int BUF_SIZE = 8,
    parameter int DEPTH    = 4,
    localparam int CNT_W   = countWidth(DEPTH)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [BUF_SIZE-1:0] data_in,
    output logic [BUF_SIZE-1:0] data_out,
    output logic                full,
    output logic                empty,
    output logic [CNT_W-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [BUF_SIZE-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [CNT_W-1:0]    r_count;
    logic                w_push;
    logic                w_pop;

    // A push on a full FIFO is dropped even when a pop frees a slot this cycle.
    assign w_push   = wr_en && !full;
    assign w_pop    = rd_en && !empty;
    assign full     = (r_count == CNT_W'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign data_out = r_mem[r_rdPtr];

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= data_in;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_write_queue.sv
// Queued parallel-to-serial writer: words stream out back-to-back, one bit per
// write_sig pulse. Define SERIAL_WRITE_QUEUE_PARITY_EN to append an even-parity bit.
module serial_write_queue
    import mitm_pkg::*;
#(
    parameter int BUF_SIZE   = 8,
    parameter int DEPTH      = 4,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b1,
    localparam int CNT_W     = countWidth(DEPTH)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [BUF_SIZE-1:0] data_in,
    output logic                full,
    output logic [CNT_W-1:0]    count,
    output logic                overflow,
    input  logic                write_sig,
    output logic                data_out,
    output logic                busy,
    output logic                word_done
);

    localparam int BIT_W = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;

    wq_state_t           r_state;
    logic [BUF_SIZE-1:0] r_shift;
    logic [BIT_W-1:0]    r_bitCnt;
    logic                r_dataOut;
    logic                r_overflow;
    logic                r_wordDone;
`ifdef SERIAL_WRITE_QUEUE_PARITY_EN
    logic                r_parity;
`endif

    logic [BUF_SIZE-1:0] w_fifoData;
    logic                w_fifoEmpty;
    logic                w_fifoFull;
    logic [CNT_W-1:0]    w_fifoCount;
    logic                w_rdEn;
    logic                w_lastBit;
    logic                w_wordEnd;
    logic [BUF_SIZE-1:0] w_nextShift;
    logic                w_loadBit;
    logic                w_nextBit;

    sync_word_fifo #(
        .BUF_SIZE (BUF_SIZE),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (w_rdEn),
        .data_in  (data_in),
        .data_out (w_fifoData),
        .full     (w_fifoFull),
        .empty    (w_fifoEmpty),
        .count    (w_fifoCount)
    );

    assign w_lastBit = (r_bitCnt == BIT_W'(BUF_SIZE - 1));

    // w_wordEnd marks the write_sig that consumes the final bit of the frame.
`ifdef SERIAL_WRITE_QUEUE_PARITY_EN
    assign w_wordEnd = (r_state == ST_PARITY) && write_sig;
`else
    assign w_wordEnd = (r_state == ST_SHIFT) && write_sig && w_lastBit;
`endif

    // Popping on the final bit lets the next word start with no idle bit.
    assign w_rdEn      = !w_fifoEmpty && ((r_state == ST_IDLE) || w_wordEnd);
    assign w_nextShift = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
    assign w_loadBit   = LSB_FIRST ? w_fifoData[0] : w_fifoData[BUF_SIZE-1];
    assign w_nextBit   = LSB_FIRST ? w_nextShift[0] : w_nextShift[BUF_SIZE-1];

    assign full      = w_fifoFull;
    assign count     = w_fifoCount;
    assign overflow  = r_overflow;
    assign data_out  = r_dataOut;
    assign word_done = r_wordDone;
    assign busy      = (r_state != ST_IDLE) || !w_fifoEmpty;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bitCnt   <= '0;
            r_dataOut  <= IDLE_LEVEL;
            r_overflow <= 1'b0;
            r_wordDone <= 1'b0;
`ifdef SERIAL_WRITE_QUEUE_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_overflow <= wr_en && w_fifoFull;
            r_wordDone <= w_wordEnd;
            if (w_rdEn) begin
                r_shift   <= w_fifoData;
                r_bitCnt  <= '0;
                r_dataOut <= w_loadBit;
                r_state   <= ST_SHIFT;
`ifdef SERIAL_WRITE_QUEUE_PARITY_EN
                r_parity  <= ^w_fifoData;
`endif
            end else begin
                case (r_state)
                    ST_SHIFT: begin
                        if (write_sig) begin
                            if (w_lastBit) begin
`ifdef SERIAL_WRITE_QUEUE_PARITY_EN
                                r_state   <= ST_PARITY;
                                r_dataOut <= r_parity;
`else
                                r_state   <= ST_IDLE;
                                r_dataOut <= IDLE_LEVEL;
`endif
                            end else begin
                                r_shift   <= w_nextShift;
                                r_bitCnt  <= r_bitCnt + BIT_W'(1);
                                r_dataOut <= w_nextBit;
                            end
                        end
                    end
`ifdef SERIAL_WRITE_QUEUE_PARITY_EN
                    ST_PARITY: begin
                        if (write_sig) begin
                            r_state   <= ST_IDLE;
                            r_dataOut <= IDLE_LEVEL;
                        end
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_write_queue.sv
// Scoreboard bench for serial_write_queue: an MSB-first and an LSB-first instance,
// hand-computed serial streams queued at push time and checked on every write_sig.
module tb_serial_write_queue;

    localparam int BUF_SIZE = 8;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;
`ifdef SERIAL_WRITE_QUEUE_PARITY_EN
    localparam int BITS = BUF_SIZE + 1;
`else
    localparam int BITS = BUF_SIZE;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                wrEnM, wrEnL;
    logic [BUF_SIZE-1:0] dataInM, dataInL;
    logic                writeSigM, writeSigL;
    logic                fullM, fullL;
    logic [CNT_W-1:0]    countM, countL;
    logic                overflowM, overflowL;
    logic                dataOutM, dataOutL;
    logic                busyM, busyL;
    logic                wordDoneM, wordDoneL;

    int checkCount = 0;
    int errorCount = 0;
    int doneM = 0;
    int doneL = 0;
    bit expM[$];
    bit expL[$];
    bit eM, eL;

    serial_write_queue #(
        .BUF_SIZE(BUF_SIZE), .DEPTH(DEPTH), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)
    ) dutM (
        .sys_clk(clk), .rst(rst), .wr_en(wrEnM), .data_in(dataInM),
        .full(fullM), .count(countM), .overflow(overflowM),
        .write_sig(writeSigM), .data_out(dataOutM), .busy(busyM),
        .word_done(wordDoneM)
    );

    serial_write_queue #(
        .BUF_SIZE(BUF_SIZE), .DEPTH(DEPTH), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)
    ) dutL (
        .sys_clk(clk), .rst(rst), .wr_en(wrEnL), .data_in(dataInL),
        .full(fullL), .count(countL), .overflow(overflowL),
        .write_sig(writeSigL), .data_out(dataOutL), .busy(busyL),
        .word_done(wordDoneL)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    // Monitors: each write_sig consumes the bit on data_out, which must match the queue head.
    always @(negedge clk) begin
        if (wordDoneM) doneM++;
        if (writeSigM) begin
            checkCount++;
            if (expM.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL bitM: actual %0b, required no bit pending", dataOutM);
            end else begin
                eM = expM.pop_front();
                if (dataOutM !== eM) begin
                    errorCount++;
                    $display("[TB] FAIL bitM: actual %0b, required %0b", dataOutM, eM);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (wordDoneL) doneL++;
        if (writeSigL) begin
            checkCount++;
            if (expL.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL bitL: actual %0b, required no bit pending", dataOutL);
            end else begin
                eL = expL.pop_front();
                if (dataOutL !== eL) begin
                    errorCount++;
                    $display("[TB] FAIL bitL: actual %0b, required %0b", dataOutL, eL);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stream lists the serial bits in emission order, first bit in stream[7].
    task automatic expectStream(input bit toL, input logic [7:0] stream, input bit par);
        for (int i = 7; i >= 0; i--) begin
            if (toL) expL.push_back(stream[i]);
            else     expM.push_back(stream[i]);
        end
`ifdef SERIAL_WRITE_QUEUE_PARITY_EN
        if (toL) expL.push_back(par);
        else     expM.push_back(par);
`else
        if (par && 1'b0) $display("[TB] unreachable");
`endif
    endtask

    task automatic pushM(input logic [7:0] w, input logic [7:0] stream, input bit par,
                         input bit expectIt);
        wrEnM   = 1'b1;
        dataInM = w;
        if (expectIt) expectStream(1'b0, stream, par);
        tick();
        wrEnM   = 1'b0;
    endtask

    task automatic pushL(input logic [7:0] w, input logic [7:0] stream, input bit par);
        wrEnL   = 1'b1;
        dataInL = w;
        expectStream(1'b1, stream, par);
        tick();
        wrEnL   = 1'b0;
    endtask

    task automatic pulseM(input int n);
        repeat (n) begin
            writeSigM = 1'b1;
            tick();
            writeSigM = 1'b0;
            tick();
        end
    endtask

    task automatic pulseL(input int n);
        repeat (n) begin
            writeSigL = 1'b1;
            tick();
            writeSigL = 1'b0;
            tick();
        end
    endtask

    task automatic applyStimulus();
        rst = 1'b1;
        wrEnM = 1'b0; wrEnL = 1'b0; dataInM = '0; dataInL = '0;
        writeSigM = 1'b0; writeSigL = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checkOutput("reset data_out", dataOutM, 1);
        checkOutput("reset full", fullM, 0);
        checkOutput("reset count", countM, 0);
        checkOutput("reset overflow", overflowM, 0);
        checkOutput("reset busy", busyM, 0);
        checkOutput("reset word_done", wordDoneM, 0);
        checkOutput("reset L data_out", dataOutL, 1);
        checkOutput("reset L count", countL, 0);

        // MSB-first single word
        pushM(8'h9C, 8'b10011100, 1'b0, 1'b1);
        checkOutput("t1 count after push", countM, 1);
        checkOutput("t1 busy after push", busyM, 1);
        tick();
        checkOutput("t1 count after pop", countM, 0);
        pulseM(BITS - 1);
        checkOutput("t1 no early word_done", doneM, 0);
        pulseM(1);
        checkOutput("t1 word_done", doneM, 1);
        checkOutput("t1 busy end", busyM, 0);
        checkOutput("t1 idle level", dataOutM, 1);

        // LSB-first single word
        pushL(8'hE4, 8'b00100111, 1'b0);
        tick();
        pulseL(BITS);
        checkOutput("t2 word_done", doneL, 1);
        checkOutput("t2 busy end", busyL, 0);
        checkOutput("t2 idle level", dataOutL, 1);

        // back-to-back words
        pushM(8'h9C, 8'b10011100, 1'b0, 1'b1);
        pushM(8'hE4, 8'b11100100, 1'b0, 1'b1);
        checkOutput("t3 count queued", countM, 1);
        pulseM(BITS);
        checkOutput("t3 count after reload", countM, 0);
        checkOutput("t3 first word_done", doneM, 2);
        checkOutput("t3 busy between", busyM, 1);
        pulseM(BITS);
        checkOutput("t3 second word_done", doneM, 3);
        checkOutput("t3 busy end", busyM, 0);

        // fill and overflow
        pushM(8'h01, 8'h01, 1'b1, 1'b1);
        pushM(8'h80, 8'h80, 1'b1, 1'b1);
        pushM(8'hA5, 8'hA5, 1'b0, 1'b1);
        pushM(8'h3C, 8'h3C, 1'b0, 1'b1);
        pushM(8'hFF, 8'hFF, 1'b0, 1'b1);
        checkOutput("t4 full", fullM, 1);
        checkOutput("t4 count full", countM, 4);
        checkOutput("t4 no overflow yet", overflowM, 0);
        pushM(8'h55, 8'h55, 1'b0, 1'b0);
        checkOutput("t4 overflow pulse", overflowM, 1);
        checkOutput("t4 count held", countM, 4);
        tick();
        checkOutput("t4 overflow cleared", overflowM, 0);
        pulseM(5 * BITS);
        checkOutput("t4 word_done total", doneM, 8);
        checkOutput("t4 busy end", busyM, 0);
        checkOutput("t4 full cleared", fullM, 0);

        // reset mid-word
        pushM(8'hE4, 8'b11100100, 1'b0, 1'b1);
        tick();
        pulseM(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expM.delete();
        checkOutput("t5 idle level", dataOutM, 1);
        checkOutput("t5 count", countM, 0);
        checkOutput("t5 busy", busyM, 0);
        tick();
        checkOutput("t5 no word_done", doneM, 8);
        pushM(8'h9C, 8'b10011100, 1'b0, 1'b1);
        tick();
        pulseM(BITS);
        checkOutput("t5 word after reset", doneM, 9);

        // parity case word
        pushM(8'h9D, 8'b10011101, 1'b1, 1'b1);
        tick();
        pulseM(BITS - 1);
        checkOutput("t6 no early word_done", doneM, 9);
        pulseM(1);
        checkOutput("t6 word_done", doneM, 10);
        checkOutput("t6 idle level", dataOutM, 1);

        checkOutput("all M bits consumed", expM.size(), 0);
        checkOutput("all L bits consumed", expL.size(), 0);
    endtask

    initial begin
        applyStimulus();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
